// File: rtl/serial_bus_pkg.sv
// Shared serial-bus definitions: state codes, default widths, state-output width.
package serial_bus_pkg;

  localparam int STATE_W = 3;
  localparam int ADN_DEF = 12;
  localparam int N_DEF   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_WDATA    = 3'd2,
    ST_MEM      = 3'd3,
    ST_HOLD     = 3'd4,
    ST_WAIT_BUS = 3'd5,
    ST_RDATA    = 3'd6
  } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first shift register with parallel load and a bit counter that wraps after W shifts.
// Load clears the counter; load has priority over shift.
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         bit_in,
  input  logic         load_en,
  input  logic [W-1:0] load_dat,
  output logic [W-1:0] q,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      cnt <= '0;
    end else if (load_en) begin
      q   <= load_dat;
      cnt <= '0;
    end else if (shift_en) begin
      // New bit enters at the MSB so that after W shifts bit 0 sits at the LSB.
      q   <= (q >> 1) | (W'(bit_in) << (W - 1));
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_bus_responder.sv
// Serial-bus slave endpoint: deserialize addr/wdata, parallel memory access, serialize rdata.
// Registered outputs; split (hold) release of the bus for slow memory when RESP_SPLIT_EN is defined.
module serial_bus_responder
  import serial_bus_pkg::*;
#(
  parameter int ADN         = ADN_DEF,
  parameter int N           = N_DEF,
  parameter int HOLD_THRESH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic               wren,
  input  logic               address_in,
  input  logic               data_in,
  input  logic               bus_available,
  input  logic               mem_ack,
  input  logic [N-1:0]       mem_rdata,
  output logic               ready,
  output logic               valid_out,
  output logic               hold,
  output logic               data_out,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADN-1:0]     mem_addr,
  output logic [N-1:0]       mem_wdata,
  output logic [STATE_W-1:0] state_out
);

  state_t       state, state_nxt;
  logic         wren_q, wren_nxt;
  logic         addr_shift, wd_shift, rd_load, rd_shift;
  logic         addr_last, wd_last, rd_last;
  logic [N-1:0] rd_q;
  logic         rd_bit1;
  logic         dout_nxt;
  logic         mem_nxt;

  serial_shift_reg #(.W(ADN)) u_addr_sr (
    .clk      (clk),
    .reset    (reset),
    .shift_en (addr_shift),
    .bit_in   (address_in),
    .load_en  (1'b0),
    .load_dat ('0),
    .q        (mem_addr),
    .last     (addr_last)
  );

  serial_shift_reg #(.W(N)) u_wdata_sr (
    .clk      (clk),
    .reset    (reset),
    .shift_en (wd_shift),
    .bit_in   (data_in),
    .load_en  (1'b0),
    .load_dat ('0),
    .q        (mem_wdata),
    .last     (wd_last)
  );

  serial_shift_reg #(.W(N)) u_rdata_sr (
    .clk      (clk),
    .reset    (reset),
    .shift_en (rd_shift),
    .bit_in   (1'b0),
    .load_en  (rd_load),
    .load_dat (mem_rdata),
    .q        (rd_q),
    .last     (rd_last)
  );

  // Bit that becomes the LSB after the current shift (0 when N is 1).
  assign rd_bit1 = |(rd_q & N'(2));

`ifdef RESP_SPLIT_EN
  localparam int WCW = (HOLD_THRESH > 1) ? $clog2(HOLD_THRESH) : 1;
  logic [WCW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != ST_MEM) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic split_unused;
  assign split_unused = bus_available ^ (HOLD_THRESH > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      wren_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wren_q <= wren_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wren_nxt   = wren_q;
    addr_shift = 1'b0;
    wd_shift   = 1'b0;
    rd_load    = 1'b0;
    rd_shift   = 1'b0;
    dout_nxt   = 1'b0;
    case (state)
      ST_IDLE: if (valid_in) begin
        addr_shift = 1'b1;
        wren_nxt   = wren;
        state_nxt  = ST_ADDR;
      end
      ST_ADDR: if (valid_in) begin
        addr_shift = 1'b1;
        if (addr_last) state_nxt = wren_q ? ST_WDATA : ST_MEM;
      end
      ST_WDATA: if (valid_in) begin
        wd_shift = 1'b1;
        if (wd_last) state_nxt = ST_MEM;
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (wren_q) begin
            state_nxt = ST_IDLE;
          end else begin
            rd_load   = 1'b1;
            dout_nxt  = mem_rdata[0];
            state_nxt = ST_RDATA;
          end
        end
`ifdef RESP_SPLIT_EN
        // Ack on the threshold cycle takes the fast path above.
        else if (wait_cnt == WCW'(HOLD_THRESH - 1)) begin
          state_nxt = ST_HOLD;
        end
`endif
      end
`ifdef RESP_SPLIT_EN
      ST_HOLD: if (mem_ack) begin
        if (wren_q) begin
          state_nxt = ST_IDLE;
        end else begin
          rd_load   = 1'b1;
          state_nxt = ST_WAIT_BUS;
        end
      end
      ST_WAIT_BUS: if (bus_available) begin
        dout_nxt  = rd_q[0];
        state_nxt = ST_RDATA;
      end
`endif
      ST_RDATA: begin
        rd_shift = 1'b1;
        if (rd_last) state_nxt = ST_IDLE;
        else         dout_nxt  = rd_bit1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_nxt = (state_nxt == ST_MEM) || (state_nxt == ST_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      ready     <= 1'b1;
      valid_out <= 1'b0;
      hold      <= 1'b0;
      data_out  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      ready     <= (state_nxt == ST_IDLE);
      valid_out <= (state_nxt == ST_RDATA);
      hold      <= (state_nxt == ST_HOLD) || (state_nxt == ST_WAIT_BUS);
      data_out  <= dout_nxt;
      mem_req   <= mem_nxt;
      mem_we    <= mem_nxt && wren_q;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_serial_bus_responder.sv
// Directed bench for serial_bus_responder; split-path expectations follow RESP_SPLIT_EN.
module tb_serial_bus_responder;

  localparam int ADN = 12;
  localparam int N   = 8;
  localparam int HT  = 4;
`ifdef RESP_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  localparam int P_IDLE = 0, P_ADDR = 1, P_WDATA = 2, P_MEM = 3, P_HOLD = 4, P_WAIT = 5, P_RDATA = 6;

  logic clk, reset, valid_in, wren, address_in, data_in, bus_available, mem_ack;
  logic [N-1:0]   mem_rdata;
  logic           ready, valid_out, hold, data_out, mem_req, mem_we;
  logic [ADN-1:0] mem_addr;
  logic [N-1:0]   mem_wdata;
  logic [2:0]     state_out;

  serial_bus_responder #(.ADN(ADN), .N(N), .HOLD_THRESH(HT)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .wren(wren),
    .address_in(address_in), .data_in(data_in), .bus_available(bus_available),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ready(ready), .valid_out(valid_out),
    .hold(hold), .data_out(data_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0, total = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle.
  logic [2:0]     e_state;
  logic           e_ready, e_req, e_hold, e_vout, e_dout;
  logic           cur_wr;
  logic [ADN-1:0] cur_a;
  logic [N-1:0]   cur_d, cur_rd;

  // Observations used by the literal checks.
  logic [N-1:0]   rx, last_wdata;
  logic [ADN-1:0] last_addr;
  logic           last_we;
  int             rx_n, hold_seen;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Output picture of each protocol phase; bi selects the read bit on the wire.
  task automatic phase(input int p, input int bi);
    e_state = 3'(p);
    e_ready = (p == P_IDLE);
    e_req   = (p == P_MEM) || (p == P_HOLD);
    e_hold  = (p == P_HOLD) || (p == P_WAIT);
    e_vout  = (p == P_RDATA);
    e_dout  = (p == P_RDATA) ? cur_rd[bi] : 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready, e_ready);
      chk("state_out", state_out, e_state);
      chk("mem_req", mem_req, e_req);
      chk("hold", hold, e_hold);
      chk("valid_out", valid_out, e_vout);
      chk("data_out", data_out, e_dout);
      if (e_req) begin
        chk("mem_we", mem_we, cur_wr);
        chk("mem_addr", mem_addr, cur_a);
        if (cur_wr) chk("mem_wdata", mem_wdata, cur_d);
      end
      if (valid_out) begin rx = {data_out, rx[N-1:1]}; rx_n++; end
      if (hold) hold_seen++;
      if (mem_req) begin last_addr = mem_addr; last_wdata = mem_wdata; last_we = mem_we; end
    end
  end

  // ack_at counts cycles from MEM entry (MEM and HOLD together); bus_at 0 means bus_available
  // is high throughout, otherwise it rises on that WAIT_BUS cycle. abort_at >= 0 resets after
  // that many write-data bits.
  task automatic do_txn(input bit wr, input logic [ADN-1:0] a, input logic [N-1:0] d,
                        input int gap_at, input int gap_len, input int abort_at,
                        input int ack_at, input logic [N-1:0] rd, input int bus_at);
    int p, k, w;
    cur_wr = wr; cur_a = a; cur_d = d; cur_rd = rd;
    rx = '0; rx_n = 0; hold_seen = 0;
    bus_available = (bus_at == 0);
    for (int i = 0; i < ADN; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          valid_in = 1'b0; address_in = ~a[i]; mem_ack = 1'b1;
          cyc();
        end
        mem_ack = 1'b0;
      end
      valid_in = 1'b1; address_in = a[i]; wren = (i == 0) ? wr : ~wr;
      cyc();
      phase((i == ADN - 1) ? (wr ? P_WDATA : P_MEM) : P_ADDR, 0);
    end
    if (wr) begin
      for (int j = 0; j < N; j++) begin
        if (j == abort_at) begin
          reset = 1'b1;
          cyc();
          phase(P_IDLE, 0);
          reset = 1'b0; valid_in = 1'b0;
          return;
        end
        valid_in = 1'b1; data_in = d[j];
        cyc();
        phase((j == N - 1) ? P_MEM : P_WDATA, 0);
      end
    end
    p = P_MEM; k = 0;
    while (p == P_MEM || p == P_HOLD) begin
      k++;
      valid_in = 1'b1; address_in = 1'($urandom); data_in = 1'($urandom);
      mem_ack = (k == ack_at);
      mem_rdata = (k == ack_at) ? rd : N'($urandom);
      cyc();
      if (k == ack_at)                          p = wr ? P_IDLE : ((p == P_MEM) ? P_RDATA : P_WAIT);
      else if (SPLIT && p == P_MEM && k == HT)  p = P_HOLD;
      phase(p, 0);
    end
    valid_in = 1'b0; mem_ack = 1'b0;
    w = 0;
    while (p == P_WAIT) begin
      w++;
      bus_available = (bus_at == 0) || (w >= bus_at);
      cyc();
      if (bus_available) p = P_RDATA;
      phase(p, 0);
    end
    bus_available = 1'b0;
    if (p == P_RDATA) begin
      for (int i = 0; i < N; i++) begin
        cyc();
        phase((i == N - 1) ? P_IDLE : P_RDATA, i + 1);
      end
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; wren = 1'b0; address_in = 1'b0; data_in = 1'b0;
    bus_available = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    cur_wr = 1'b0; cur_a = '0; cur_d = '0; cur_rd = '0;
    rx = '0; rx_n = 0; hold_seen = 0; last_addr = '0; last_wdata = '0; last_we = 1'b0;
    cyc(); phase(P_IDLE, 0); chk_en = 1'b1;
    cyc(); phase(P_IDLE, 0);
    reset = 1'b0;
    cyc(); phase(P_IDLE, 0);
    chk("rst ready", ready, 1);
    chk("rst state", state_out, 0);
    chk("rst outs", {valid_out, hold, data_out, mem_req, mem_we}, 0);
    chk("rst addr", mem_addr, 0);

    // Write 0x5A3 <- 0xC7, ack on the second MEM cycle.
    do_txn(1'b1, 12'h5A3, 8'hC7, -1, 0, -1, 2, 8'h00, 1);
    chk("wr addr", last_addr, 12'h5A3);
    chk("wr data", last_wdata, 8'hC7);
    chk("wr we", last_we, 1);
    chk("wr ready", ready, 1);

    // Fast read: ack in first MEM cycle, 0x96 on the wire LSB first.
    do_txn(1'b0, 12'h010, 8'h00, -1, 0, -1, 1, 8'h96, 1);
    chk("fast rd bits", rx, 8'h96);
    chk("fast rd count", rx_n, 8);
    chk("fast rd addr", last_addr, 12'h010);

    // Slow read: ack at MEM cycle 10, bus back on the 3rd WAIT_BUS cycle.
    do_txn(1'b0, 12'h2C4, 8'h00, -1, 0, -1, 10, 8'h3C, 3);
    chk("slow rd bits", rx, 8'h3C);
    chk("slow hold cycles", hold_seen, SPLIT ? 9 : 0);

    // Two idle cycles between address bits 4 and 5.
    do_txn(1'b1, 12'h5A3, 8'h11, 5, 2, -1, 1, 8'h00, 1);
    chk("gap addr", last_addr, 12'h5A3);
    chk("gap data", last_wdata, 8'h11);

    // Reset after three write-data bits, then a clean write.
    do_txn(1'b1, 12'h2B7, 8'hFF, -1, 0, 3, 1, 8'h00, 1);
    chk("abort req", mem_req, 0);
    chk("abort ready", ready, 1);
    chk("abort state", state_out, 0);
    do_txn(1'b1, 12'h0FF, 8'h5E, -1, 0, -1, 3, 8'h00, 1);
    chk("post addr", last_addr, 12'h0FF);
    chk("post data", last_wdata, 8'h5E);

    // Ack on the threshold cycle: no hold at all.
    do_txn(1'b0, 12'h7C1, 8'h00, -1, 0, -1, HT, 8'hA5, 1);
    chk("coinc hold", hold_seen, 0);
    chk("coinc bits", rx, 8'hA5);

    // bus_available already high when WAIT_BUS is entered.
    do_txn(1'b0, 12'h123, 8'h00, -1, 0, -1, 6, 8'h81, 0);
    chk("bus pre bits", rx, 8'h81);
    chk("bus pre hold", hold_seen, SPLIT ? 3 : 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
